line_fill_ctrl: RTL and testbench
=================================

# line_fill_ctrl

Miss-service engine sitting between the instruction/data caches and main memory. It watches the two cache miss lines, arbitrates, fetches the 8-byte line from a 32-bit memory port in two handshaked beats, assembles it into the 64-bit fill word, and pulses the matching cache's fill strobe for one cycle. It also drives the core stall while a miss is outstanding.

## Interface
- ADDR_W, 32, byte address width; line = 8 bytes, tag = addr[31:8], idx = addr[7:3], byte = addr[2:0]

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_miss  in  1  icache tag miss (combinational from tag store)
- i_addr  in  ADDR_W  fetch address causing i_miss
- d_miss  in  1  dcache tag miss
- d_addr  in  ADDR_W  load/store address causing d_miss
- mem_req  out  1  memory read request, held until acked
- mem_addr  out  ADDR_W  word address of current beat, 4-byte aligned
- mem_ack  in  1  memory accepts request; mem_rdata valid this cycle
- mem_rdata  in  32  read data, valid only when mem_ack=1
- line_out  out  64  assembled line to both caches' data_mem and fill path
- i_fill  out  1  one-cycle fill strobe to icache data and tag stores
- d_fill  out  1  one-cycle fill strobe to dcache data and tag stores
- stall  out  1  freeze core pipeline

## Operation
- States: IDLE, BEAT0, BEAT1, FILL. Grant register src (I or D) and base register base = {addr[ADDR_W-1:3], 3'b000}.
- IDLE: if d_miss, grant D, latch base from d_addr; else if i_miss, grant I, latch base from i_addr; either way -> BEAT0. No miss: stay.
- Priority: dcache always wins simultaneous misses; icache miss remains asserted and is served in the next transaction.
- BEAT0: mem_req=1, mem_addr=base. On edge with mem_ack=1: line_out[31:0] <= mem_rdata, -> BEAT1. Else hold req and address unchanged.
- BEAT1: mem_req=1, mem_addr=base+4. On ack: line_out[63:32] <= mem_rdata, -> FILL.
- FILL: mem_req=0; d_fill=1 if src=D else i_fill=1, for exactly this cycle; -> IDLE. Cache writes tag and line at this edge, so the miss drops in the following IDLE cycle.
- Byte order little-endian: line byte k = line_out[8k+7:8k], matching cache byte lanes.
- Miss inputs and addresses are sampled only in IDLE; deassertion mid-transaction does not abort it (core holds address while stalled). Fill still pulses.
- mem_ack while mem_req=0 is ignored; mem_rdata is never captured without ack.
- stall = (state != IDLE) | i_miss | d_miss (combinational).
- line_out holds its last value between transactions; never cleared except by reset.
- i_fill and d_fill are never high together, never high outside FILL.

## Timing
- Reset values: state IDLE, mem_req 0, mem_addr 0, line_out 0, i_fill 0, d_fill 0, src D, base 0; stall follows i_miss|d_miss.
- Reset mid-transaction: next cycle in IDLE with mem_req 0, no fill pulse; a still-asserted miss restarts from BEAT0 after reset releases.
- Zero-wait memory (ack in same cycle as req): miss seen in IDLE at cycle 0, BEAT0 cycle 1, BEAT1 cycle 2, fill high cycle 3, IDLE cycle 4. Latency miss-to-fill = 3 + total wait cycles.
- mem_req, mem_addr, fills are registered state decodes (no combinational path from mem_ack or miss inputs); only stall is combinational.
- Back-to-back misses: minimum one IDLE cycle between FILL and next BEAT0.

## Test plan
- Reset then d_miss=1, d_addr=0x0000_1234, zero-wait memory returning 0xA0A1A2A3 at 0x1230, 0xB0B1B2B3 at 0x1234 -> mem_addr 0x1230 then 0x1234, d_fill high only in cycle 3, line_out=0xB0B1B2B3_A0A1A2A3, i_fill stays 0.
- Simultaneous i_miss (0x400) and d_miss (0x808) -> dcache served first (addrs 0x808,0x80C), d_fill; then after IDLE cycle icache served (0x400,0x404), i_fill; stall high throughout.
- Memory inserts 2 wait cycles on each beat -> mem_req and mem_addr stable while ack low, fill at cycle 7, mem_rdata garbage during wait cycles not captured.
- rst asserted during BEAT1 -> mem_req 0 next cycle, no fill pulse, line_out 0; miss held -> new transaction restarts at base address.
- Spurious mem_ack pulses in IDLE with no miss -> no state change, line_out unchanged, stall 0.
- i_miss deasserted during BEAT0 -> transaction completes, i_fill still pulses once, then IDLE with stall 0.

Source files
------------

// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: cache miss-service engine. Arbitrates icache/dcache misses,
// fetches an 8-byte line as two 32-bit memory beats, pulses the fill strobe.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_miss/i_addr        icache miss and its address
//   d_miss/d_addr        dcache miss and its address (wins ties)
//   mem_req/mem_addr     memory read request and beat word address
//   mem_ack/mem_rdata    memory accept and read data
//   line_out             assembled 64-bit line, little-endian beats
//   i_fill/d_fill        one-cycle fill strobes
//   stall                core pipeline freeze (combinational)
module line_fill_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [63:0]       line_out,
    output logic              i_fill,
    output logic              d_fill,
    output logic              stall
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_FILL  = 2'd3;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              src_q, src_d;
    // Line base kept without the byte-offset bits; they are always zero.
    logic [ADDR_W-4:0] base_q, base_d;
    logic [63:0]       line_q, line_d;

    // Byte offsets of the miss addresses do not matter for a line fetch.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[2:0], d_addr[2:0]};

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        base_d  = base_q;
        line_d  = line_q;
        unique case (state_q)
            S_IDLE: begin
                if (d_miss) begin
                    src_d   = SRC_D;
                    base_d  = d_addr[ADDR_W-1:3];
                    state_d = S_BEAT0;
                end else if (i_miss) begin
                    src_d   = SRC_I;
                    base_d  = i_addr[ADDR_W-1:3];
                    state_d = S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (mem_ack) begin
                    line_d[31:0] = mem_rdata;
                    state_d      = S_BEAT1;
                end
            end
            S_BEAT1: begin
                if (mem_ack) begin
                    line_d[63:32] = mem_rdata;
                    state_d       = S_FILL;
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= SRC_D;
            base_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            base_q  <= base_d;
            line_q  <= line_d;
        end
    end

    // All memory and fill outputs decode registered state only.
    assign mem_req  = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    // Second beat sets address bit 2; base is 8-byte aligned so no adder.
    assign mem_addr = {base_q, (state_q == S_BEAT1), 2'b00};
    assign line_out = line_q;
    assign i_fill   = (state_q == S_FILL) && (src_q == SRC_I);
    assign d_fill   = (state_q == S_FILL) && (src_q == SRC_D);
    assign stall    = (state_q != S_IDLE) || i_miss || d_miss;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// tb_line_fill_ctrl: scoreboard bench for line_fill_ctrl.
// Directed stimulus pushes expected beats/fills; a monitor pops and compares.
module tb_line_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss;
    logic [31:0] i_addr;
    logic        d_miss;
    logic [31:0] d_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [63:0] line_out;
    logic        i_fill;
    logic        d_fill;
    logic        stall;

    line_fill_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_miss    (i_miss),
        .i_addr    (i_addr),
        .d_miss    (d_miss),
        .d_addr    (d_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .line_out  (line_out),
        .i_fill    (i_fill),
        .d_fill    (d_fill),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  who;   // {i_fill, d_fill}
        logic [63:0] line;
        logic [31:0] at;
    } fill_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          wait_n   = 0;
    int          wc       = 0;
    logic        spur     = 1'b0;
    logic [31:0] exp_addr_q[$];
    fill_t       exp_fill_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0000_1230: mem_fn = 32'hA0A1_A2A3;
            32'h0000_1234: mem_fn = 32'hB0B1_B2B3;
            32'h0000_0808: mem_fn = 32'h1122_3344;
            32'h0000_080C: mem_fn = 32'h5566_7788;
            32'h0000_0400: mem_fn = 32'hC0C1_C2C3;
            32'h0000_0404: mem_fn = 32'hD0D1_D2D3;
            default:       mem_fn = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Memory model: wait_n wait cycles per beat, garbage data when not acking.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (wc >= wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_fn(mem_addr);
                    wc        = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hBAD0_0000 | 32'(wc);
                    wc++;
                end
            end else begin
                mem_ack   = spur;
                mem_rdata = 32'hFFFF_EEEE;
                wc        = 0;
            end
        end
    end

    // Monitor: handshakes and fill strobes pop the scoreboard.
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    initial begin
        fill_t f;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("fill_excl", {63'b0, i_fill & d_fill}, 64'd0);
                if (mem_req && !mem_ack && prev_wait)
                    chk("addr_hold", {32'b0, mem_addr}, {32'b0, prev_addr});
                if (mem_req && mem_ack) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL beat_unexp: got addr %h expected none",
                                 mem_addr);
                    end else begin
                        chk("beat_addr", {32'b0, mem_addr},
                            {32'b0, exp_addr_q.pop_front()});
                    end
                end
                if (i_fill || d_fill) begin
                    if (exp_fill_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL fill_unexp: got %b expected none",
                                 {i_fill, d_fill});
                    end else begin
                        f = exp_fill_q.pop_front();
                        chk("fill_who", {62'b0, i_fill, d_fill}, {62'b0, f.who});
                        chk("fill_line", line_out, f.line);
                        chk("fill_cycle", 64'(cyc), {32'b0, f.at});
                    end
                end
            end
            prev_wait = mem_req && !mem_ack;
            prev_addr = mem_addr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_fill(input logic [1:0] who, input logic [63:0] ln,
                             input int at);
        fill_t f;
        f.who  = who;
        f.line = ln;
        f.at   = 32'(at);
        exp_fill_q.push_back(f);
    endtask

    int k;

    initial begin
        rst    = 1'b1;
        i_miss = 1'b0;
        d_miss = 1'b0;
        i_addr = '0;
        d_addr = '0;
        step(2);
        chk("rst_req", {63'b0, mem_req}, 64'd0);
        chk("rst_addr", {32'b0, mem_addr}, 64'd0);
        chk("rst_line", line_out, 64'd0);
        chk("rst_fill", {62'b0, i_fill, d_fill}, 64'd0);
        chk("rst_stall0", {63'b0, stall}, 64'd0);
        d_miss = 1'b1;
        #1;
        chk("rst_stall1", {63'b0, stall}, 64'd1);
        d_miss = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);

        // Zero-wait dcache fill.
        d_addr = 32'h0000_1234;
        d_miss = 1'b1;
        k = cyc;
        exp_addr_q.push_back(32'h0000_1230);
        exp_addr_q.push_back(32'h0000_1234);
        push_fill(2'b01, 64'hB0B1B2B3_A0A1A2A3, k + 3);
        step(4);
        d_miss = 1'b0;
        #1;
        chk("t1_stall", {63'b0, stall}, 64'd0);
        chk("t1_hold", line_out, 64'hB0B1B2B3_A0A1A2A3);
        step(2);

        // Simultaneous misses: dcache first, then icache.
        i_addr = 32'h0000_0400;
        d_addr = 32'h0000_0808;
        i_miss = 1'b1;
        d_miss = 1'b1;
        k = cyc;
        exp_addr_q.push_back(32'h0000_0808);
        exp_addr_q.push_back(32'h0000_080C);
        exp_addr_q.push_back(32'h0000_0400);
        exp_addr_q.push_back(32'h0000_0404);
        push_fill(2'b01, 64'h55667788_11223344, k + 3);
        push_fill(2'b10, 64'hD0D1D2D3_C0C1C2C3, k + 7);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_stall", {63'b0, stall}, 64'd1);
            step(1);
        end
        d_miss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_stall", {63'b0, stall}, 64'd1);
            step(1);
        end
        i_miss = 1'b0;
        #1;
        chk("t2_stall_end", {63'b0, stall}, 64'd0);
        step(1);

        // Two wait cycles per beat, unaligned miss address.
        wait_n = 2;
        step(1);
        d_addr = 32'h0000_080F;
        d_miss = 1'b1;
        k = cyc;
        exp_addr_q.push_back(32'h0000_0808);
        exp_addr_q.push_back(32'h0000_080C);
        push_fill(2'b01, 64'h55667788_11223344, k + 7);
        step(8);
        d_miss = 1'b0;
        step(1);

        // Reset during BEAT1, miss held, restart from base.
        d_addr = 32'h0000_1234;
        d_miss = 1'b1;
        k = cyc;
        exp_addr_q.push_back(32'h0000_1230);
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        chk("t4_req", {63'b0, mem_req}, 64'd0);
        chk("t4_line", line_out, 64'd0);
        chk("t4_fill", {62'b0, i_fill, d_fill}, 64'd0);
        chk("t4_stall", {63'b0, stall}, 64'd1);
        wait_n = 0;
        k = cyc;
        exp_addr_q.push_back(32'h0000_1230);
        exp_addr_q.push_back(32'h0000_1234);
        push_fill(2'b01, 64'hB0B1B2B3_A0A1A2A3, k + 3);
        step(4);
        d_miss = 1'b0;
        step(1);

        // Spurious acks while idle.
        spur = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            #1;
            chk("t5_req", {63'b0, mem_req}, 64'd0);
            chk("t5_stall", {63'b0, stall}, 64'd0);
            chk("t5_line", line_out, 64'hB0B1B2B3_A0A1A2A3);
        end
        spur = 1'b0;
        step(2);

        // icache miss dropped during BEAT0, one wait per beat.
        wait_n = 1;
        step(1);
        i_addr = 32'h0000_0404;
        i_miss = 1'b1;
        k = cyc;
        exp_addr_q.push_back(32'h0000_0400);
        exp_addr_q.push_back(32'h0000_0404);
        push_fill(2'b10, 64'hD0D1D2D3_C0C1C2C3, k + 5);
        step(1);
        i_miss = 1'b0;
        #1;
        chk("t6_stall_busy", {63'b0, stall}, 64'd1);
        step(5);
        #1;
        chk("t6_stall_end", {63'b0, stall}, 64'd0);
        chk("t6_req", {63'b0, mem_req}, 64'd0);

        step(3);
        chk("left_beats", 64'(exp_addr_q.size()), 64'd0);
        chk("left_fills", 64'(exp_fill_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
